char_buffer_controller: RTL



---
 rtl/char_buffer_controller.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/char_buffer_controller.sv
// Write-side owner of the character RAM: power-on clear, then edit commands become one RAM write per cycle.
// Writes start the cycle after accept; cmd_ready stays low until the cycle after the last write, and requests made while busy are ignored.
module char_buffer_controller #(
   parameter int          ROWS      = 24,
   parameter int          COLS      = 80,
   parameter int          ROW_BITS  = 5,
   parameter int          COL_BITS  = 7,
   parameter int          ADDR_BITS = 11,
   parameter logic [7:0]  BLANK     = 8'h20
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [COL_BITS-1:0]  cmd_x,
   input  logic [ROW_BITS-1:0]  cmd_y,
   input  logic [7:0]           cmd_char,
   output logic                 cmd_done,
   output logic                 busy,
   output logic                 wr_en,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [7:0]           wr_data,
   output logic [ROW_BITS-1:0]  top_row
);

   localparam int CNT_BITS  = ADDR_BITS + 1;
   localparam int RSUM_BITS = ROW_BITS + 1;

   localparam logic [2:0] OP_WRITE  = 3'd0;
   localparam logic [2:0] OP_SCROLL = 3'd1;
   localparam logic [2:0] OP_EOL    = 3'd2;
   localparam logic [2:0] OP_EOS    = 3'd3;
   localparam logic [2:0] OP_CLEAR  = 3'd4;

   localparam logic [COL_BITS-1:0]  COLS_C   = COL_BITS'(COLS);
   localparam logic [COL_BITS-1:0]  COL_LAST = COL_BITS'(COLS - 1);
   localparam logic [ROW_BITS-1:0]  ROWS_R   = ROW_BITS'(ROWS);
   localparam logic [ROW_BITS-1:0]  ROW_LAST = ROW_BITS'(ROWS - 1);
   localparam logic [RSUM_BITS-1:0] ROWS_W   = RSUM_BITS'(ROWS);
   localparam logic [ADDR_BITS-1:0] COLS_A   = ADDR_BITS'(COLS);
   localparam logic [CNT_BITS-1:0]  COLS_N   = CNT_BITS'(COLS);
   localparam logic [CNT_BITS-1:0]  TOTAL    = CNT_BITS'(ROWS * COLS);
   localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0]  CNT_TWO  = CNT_BITS'(2);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE, S_FILL} state_t;

   // Constant table of row*COLS built from running sums, so no multiplier is inferred.
   function automatic logic [ADDR_BITS-1:0] f_row_base(input logic [ROW_BITS-1:0] row);
      logic [ADDR_BITS-1:0] acc;
      logic [ADDR_BITS-1:0] res;
      acc = '0;
      res = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (row == ROW_BITS'(i)) res = acc;
         acc = acc + COLS_A;
      end
      return res;
   endfunction

   state_t                r_state, w_state_nxt;
   logic [COL_BITS-1:0]   r_col, w_col_nxt;
   logic [ROW_BITS-1:0]   r_phys, w_phys_nxt;
   logic [ADDR_BITS-1:0]  r_row_base, w_base_nxt;
   logic [CNT_BITS-1:0]   r_remain, w_remain_nxt;
   logic                  r_init, w_init_nxt;
   logic                  r_wr_en, w_wr_en_nxt;
   logic [ADDR_BITS-1:0]  r_wr_addr, w_wr_addr_nxt;
   logic [7:0]            r_wr_data, w_wr_data_nxt;
   logic                  r_cmd_done, w_done_nxt;
   logic                  r_cmd_ready, w_ready_nxt;
   logic                  r_busy;
   logic [ROW_BITS-1:0]   r_top_row, w_top_nxt;

   logic                  w_accept;
   logic                  w_x_ok, w_y_ok;
   logic [RSUM_BITS-1:0]  w_row_sum;
   logic [ROW_BITS-1:0]   w_cmd_phys;
   logic [ADDR_BITS-1:0]  w_x_ext;

   logic                  w_st_fill, w_st_we;
   logic [ROW_BITS-1:0]   w_st_phys;
   logic [COL_BITS-1:0]   w_st_col;
   logic [CNT_BITS-1:0]   w_st_cnt;
   logic [ROW_BITS-1:0]   w_top_cmd;
   logic [ADDR_BITS-1:0]  w_st_base, w_st_addr;

   logic                  w_last_col, w_last_row;
   logic [COL_BITS-1:0]   w_step_col;
   logic [ROW_BITS-1:0]   w_step_phys;
   logic [ADDR_BITS-1:0]  w_step_base, w_step_addr;

   assign w_accept   = cmd_valid && r_cmd_ready;
   assign w_x_ok     = cmd_x < COLS_C;
   assign w_y_ok     = cmd_y < ROWS_R;
   assign w_row_sum  = {1'b0, cmd_y} + {1'b0, r_top_row};
   assign w_cmd_phys = (w_row_sum >= ROWS_W) ? ROW_BITS'(w_row_sum - ROWS_W) : ROW_BITS'(w_row_sum);
   assign w_x_ext    = {{(ADDR_BITS-COL_BITS){1'b0}}, cmd_x};

   // Command decode: where the first write lands and how many writes follow.
   always_comb begin
      w_st_fill = 1'b0;
      w_st_we   = 1'b0;
      w_st_phys = w_cmd_phys;
      w_st_col  = cmd_x;
      w_st_cnt  = CNT_ONE;
      w_top_cmd = r_top_row;
      case (cmd_op)
         OP_WRITE: w_st_we = w_x_ok && w_y_ok;
         OP_SCROLL: begin
            w_st_fill = 1'b1;
            w_st_phys = r_top_row;
            w_st_col  = '0;
            w_st_cnt  = COLS_N;
            w_top_cmd = (r_top_row == ROW_LAST) ? '0 : r_top_row + ROW_BITS'(1);
         end
         OP_EOL: begin
            if (w_x_ok && w_y_ok) begin
               w_st_fill = 1'b1;
               w_st_cnt  = COLS_N - {{(CNT_BITS-COL_BITS){1'b0}}, cmd_x};
            end
         end
         OP_EOS: begin
            if (w_x_ok && w_y_ok) begin
               w_st_fill = 1'b1;
               w_st_cnt  = TOTAL - {1'b0, f_row_base(cmd_y) + w_x_ext};
            end
         end
         OP_CLEAR: begin
            w_st_fill = 1'b1;
            w_st_phys = '0;
            w_st_col  = '0;
            w_st_cnt  = TOTAL;
            w_top_cmd = '0;
         end
         default: ;
      endcase
   end

   assign w_st_base = f_row_base(w_st_phys);
   assign w_st_addr = w_st_base + {{(ADDR_BITS-COL_BITS){1'b0}}, w_st_col};

   // Fill walker: column wraps into the next physical row, last row wraps to row 0.
   assign w_last_col  = r_col == COL_LAST;
   assign w_last_row  = r_phys == ROW_LAST;
   assign w_step_col  = w_last_col ? '0 : r_col + COL_BITS'(1);
   assign w_step_phys = !w_last_col ? r_phys : (w_last_row ? '0 : r_phys + ROW_BITS'(1));
   assign w_step_base = !w_last_col ? r_row_base : (w_last_row ? '0 : r_row_base + COLS_A);
   assign w_step_addr = w_step_base + {{(ADDR_BITS-COL_BITS){1'b0}}, w_step_col};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_INIT;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  w_state_nxt = S_FILL;
         S_IDLE:  if (w_accept) w_state_nxt = w_st_fill ? S_FILL : S_WRITE;
         S_WRITE: w_state_nxt = S_IDLE;
         S_FILL:  if (r_remain == CNT_ONE) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      w_wr_en_nxt   = 1'b0;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_done_nxt    = 1'b0;
      w_ready_nxt   = r_cmd_ready;
      w_top_nxt     = r_top_row;
      w_col_nxt     = r_col;
      w_phys_nxt    = r_phys;
      w_base_nxt    = r_row_base;
      w_remain_nxt  = r_remain;
      w_init_nxt    = r_init;
      case (r_state)
         S_INIT: begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = '0;
            w_wr_data_nxt = BLANK;
            w_col_nxt     = '0;
            w_phys_nxt    = '0;
            w_base_nxt    = '0;
            w_remain_nxt  = TOTAL;
            w_init_nxt    = 1'b1;
            w_ready_nxt   = 1'b0;
         end
         S_IDLE: begin
            if (w_accept) begin
               w_ready_nxt = 1'b0;
               w_top_nxt   = w_top_cmd;
               if (w_st_fill) begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = w_st_addr;
                  w_wr_data_nxt = BLANK;
                  w_col_nxt     = w_st_col;
                  w_phys_nxt    = w_st_phys;
                  w_base_nxt    = w_st_base;
                  w_remain_nxt  = w_st_cnt;
                  w_init_nxt    = 1'b0;
                  w_done_nxt    = w_st_cnt == CNT_ONE;
               end else begin
                  w_done_nxt = 1'b1;
                  if (w_st_we) begin
                     w_wr_en_nxt   = 1'b1;
                     w_wr_addr_nxt = w_st_addr;
                     w_wr_data_nxt = cmd_char;
                  end
               end
            end
         end
         S_WRITE: w_ready_nxt = 1'b1;
         S_FILL: begin
            if (r_remain == CNT_ONE) begin
               w_ready_nxt = 1'b1;
            end else begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = w_step_addr;
               w_wr_data_nxt = BLANK;
               w_col_nxt     = w_step_col;
               w_phys_nxt    = w_step_phys;
               w_base_nxt    = w_step_base;
               w_remain_nxt  = r_remain - CNT_ONE;
               // The power-on clear completes silently.
               w_done_nxt    = (r_remain == CNT_TWO) && !r_init;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_cmd_done  <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b1;
         r_top_row   <= '0;
         r_col       <= '0;
         r_phys      <= '0;
         r_row_base  <= '0;
         r_remain    <= '0;
         r_init      <= 1'b1;
      end else begin
         r_wr_en     <= w_wr_en_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_wr_data   <= w_wr_data_nxt;
         r_cmd_done  <= w_done_nxt;
         r_cmd_ready <= w_ready_nxt;
         r_busy      <= !w_ready_nxt;
         r_top_row   <= w_top_nxt;
         r_col       <= w_col_nxt;
         r_phys      <= w_phys_nxt;
         r_row_base  <= w_base_nxt;
         r_remain    <= w_remain_nxt;
         r_init      <= w_init_nxt;
      end
   end

   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign cmd_done  = r_cmd_done;
   assign cmd_ready = r_cmd_ready;
   assign busy      = r_busy;
   assign top_row   = r_top_row;

endmodule
